// File: rtl/axi_isolate_drain_ctrl.sv
// Handshake-level isolation controller for the master side of an AXI slice.
// Blocks new AW/AR, drains in-flight work, then reports isolation; payloads bypass it.
module axi_isolate_drain_ctrl #(
  parameter int MAX_WR_TXNS    = 8,
  parameter int MAX_RD_TXNS    = 8,
  parameter bit RESET_ISOLATED = 1'b1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               isolate_req_i,
  input  logic                               clock_down_i,
  output logic                               isolated_o,
  output logic                               incoming_req_o,
  output logic                               unexp_rsp_o,
  output logic [$clog2(MAX_WR_TXNS+1)-1:0]   wr_cnt_o,
  output logic [$clog2(MAX_RD_TXNS+1)-1:0]   rd_cnt_o,
  input  logic                               s_aw_valid,
  output logic                               s_aw_ready,
  input  logic                               s_w_valid,
  output logic                               s_w_ready,
  input  logic                               s_w_last,
  input  logic                               s_ar_valid,
  output logic                               s_ar_ready,
  output logic                               s_r_valid,
  input  logic                               s_r_ready,
  output logic                               s_b_valid,
  input  logic                               s_b_ready,
  output logic                               m_aw_valid,
  input  logic                               m_aw_ready,
  output logic                               m_w_valid,
  input  logic                               m_w_ready,
  output logic                               m_ar_valid,
  input  logic                               m_ar_ready,
  input  logic                               m_r_valid,
  output logic                               m_r_ready,
  input  logic                               m_r_last,
  input  logic                               m_b_valid,
  output logic                               m_b_ready
);

  localparam int WCW = $clog2(MAX_WR_TXNS + 1);
  localparam int RCW = $clog2(MAX_RD_TXNS + 1);
  localparam int WBW = WCW + 1;
  localparam logic [WCW-1:0] WR_MAX = WCW'(MAX_WR_TXNS);
  localparam logic [RCW-1:0] RD_MAX = RCW'(MAX_RD_TXNS);

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_DRAIN,
    ST_ISOLATED
  } state_t;

  localparam state_t RESET_STATE = RESET_ISOLATED ? ST_ISOLATED : ST_NORMAL;

  state_t                state;
  logic [WCW-1:0]        wr_cnt;
  logic [RCW-1:0]        rd_cnt;
  logic signed [WBW-1:0] wbal;
  logic                  aw_commit, ar_commit, w_commit;

  logic is_normal, is_iso;
  logic aw_open, ar_open, w_open;
  logic aw_hs, ar_hs, w_last_hs, b_hs, r_last_hs;
  logic drained;

  assign is_normal = (state == ST_NORMAL);
  assign is_iso    = (state == ST_ISOLATED);

  assign aw_open = is_normal & ~clock_down_i & (wr_cnt < WR_MAX);
  assign ar_open = is_normal & ~clock_down_i & (rd_cnt < RD_MAX);
  assign w_open  = ~is_iso & ~clock_down_i;

  // A commit flag keeps valid asserted once presented, so gating never retracts it.
  assign m_aw_valid = s_aw_valid & (aw_open | aw_commit);
  assign m_ar_valid = s_ar_valid & (ar_open | ar_commit);
  assign m_w_valid  = s_w_valid & (w_open | w_commit);

  assign aw_hs     = m_aw_valid & m_aw_ready;
  assign ar_hs     = m_ar_valid & m_ar_ready;
  assign w_last_hs = m_w_valid & m_w_ready & s_w_last;

  assign s_aw_ready = aw_hs;
  assign s_ar_ready = ar_hs;
  assign s_w_ready  = m_w_valid & m_w_ready;

  assign s_b_valid = is_iso ? 1'b0 : m_b_valid;
  assign s_r_valid = is_iso ? 1'b0 : m_r_valid;
  assign m_b_ready = is_iso ? 1'b1 : s_b_ready;
  assign m_r_ready = is_iso ? 1'b1 : s_r_ready;

  assign b_hs      = m_b_valid & m_b_ready;
  assign r_last_hs = m_r_valid & m_r_ready & m_r_last;

  assign drained = (wr_cnt == '0) && (rd_cnt == '0) && (wbal == '0)
                 && !aw_commit && !ar_commit && !w_commit;

  assign incoming_req_o = s_aw_valid | s_ar_valid;
  assign isolated_o     = is_iso;
  assign wr_cnt_o       = wr_cnt;
  assign rd_cnt_o       = rd_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= RESET_STATE;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wbal        <= '0;
      aw_commit   <= 1'b0;
      ar_commit   <= 1'b0;
      w_commit    <= 1'b0;
      unexp_rsp_o <= 1'b0;
    end else begin
      aw_commit <= m_aw_valid & ~m_aw_ready;
      ar_commit <= m_ar_valid & ~m_ar_ready;
      w_commit  <= m_w_valid & ~m_w_ready;

      if (aw_hs && !b_hs)
        wr_cnt <= wr_cnt + WCW'(1);
      else if (!aw_hs && b_hs && wr_cnt != '0)
        wr_cnt <= wr_cnt - WCW'(1);

      if (ar_hs && !r_last_hs)
        rd_cnt <= rd_cnt + RCW'(1);
      else if (!ar_hs && r_last_hs && rd_cnt != '0)
        rd_cnt <= rd_cnt - RCW'(1);

      // W may lead AW, so the balance is allowed to go negative.
      if (aw_hs && !w_last_hs)
        wbal <= wbal + WBW'(1);
      else if (!aw_hs && w_last_hs)
        wbal <= wbal - WBW'(1);

      unexp_rsp_o <= (b_hs && !aw_hs && wr_cnt == '0)
                  || (r_last_hs && !ar_hs && rd_cnt == '0);

      case (state)
        ST_NORMAL:   if (isolate_req_i) state <= ST_DRAIN;
        ST_DRAIN:    if (!isolate_req_i) state <= ST_NORMAL;
                     else if (drained)   state <= ST_ISOLATED;
        ST_ISOLATED: if (!isolate_req_i) state <= ST_NORMAL;
        default:     state <= RESET_STATE;
      endcase
    end
  end

endmodule
